// File: rtl/calc_core_param.sv
`default_nettype none
// ============================================================================
// Module      : calc_core_param
// Description : Keypad-driven two-operand calculator core with a sequential
//               double-dabble binary-to-BCD converter and busy/valid handshake.
//               Optional multiply enabled by macro CALC_MUL_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module calc_core_param #(
    parameter int NDIG = 4,
    parameter int OPW  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_num,
    input  logic                is_op1,
    input  logic                is_op2,
    input  logic [3:0]          num_val,
    input  logic [3:0]          op_val,
    input  logic                save,
    output logic [OPW-1:0]      op1_bin,
    output logic [OPW-1:0]      op2_bin,
    output logic [4*NDIG-1:0]   alu_result_bcd,
    output logic                f_OF,
    output logic                f_sig_res,
    output logic                busy,
    output logic                valid
);

    localparam int CW = $clog2(NDIG + 1);
    localparam int IW = $clog2(OPW + 1);
    localparam int BW = 4 * NDIG;
    localparam int MW = 2 * OPW;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_CONV = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
`ifdef CALC_MUL_EN
    localparam logic [1:0] c_OP_MUL = 2'd2;
`endif

    localparam logic [MW-1:0] c_MAX_VAL   = MW'(10 ** NDIG - 1);
    localparam logic [CW-1:0] c_NDIG      = CW'(NDIG);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] c_LAST_ITER = IW'(OPW - 1);
    localparam logic [IW-1:0] c_ITER_ONE  = IW'(1);

    logic [1:0]     r_state;
    logic [1:0]     r_opcode;
    logic [OPW-1:0] r_op1;
    logic [OPW-1:0] r_op2;
    logic [CW-1:0]  r_cnt1;
    logic [CW-1:0]  r_cnt2;
    logic           r_fresh1;
    logic           r_fresh2;
    logic [OPW-1:0] r_bin;
    logic [BW-1:0]  r_bcd;
    logic [IW-1:0]  r_iter;
    logic           r_neg;
    logic [BW-1:0]  r_res_bcd;
    logic           r_of;
    logic           r_sign;
    logic           r_busy;
    logic           r_valid;

    logic           w_op_legal;
    logic [1:0]     w_op_code;
    logic [MW-1:0]  w_a;
    logic [MW-1:0]  w_b;
    logic [MW-1:0]  w_mag;
    logic           w_neg;
    logic           w_ovf;
    logic           w_dig_ok;
    logic [OPW-1:0] w_num_ext;
    logic [OPW-1:0] w_op1_x10;
    logic [OPW-1:0] w_op2_x10;
    logic [BW-1:0]  w_bcd_adj;
    logic [BW-1:0]  w_bcd_next;
    logic           w_unused;

    always_comb begin
        w_op_legal = 1'b0;
        w_op_code  = c_OP_ADD;
        case (op_val)
            4'b1101: begin w_op_legal = 1'b1; w_op_code = c_OP_ADD; end
            4'b1110: begin w_op_legal = 1'b1; w_op_code = c_OP_SUB; end
`ifdef CALC_MUL_EN
            4'b1100: begin w_op_legal = 1'b1; w_op_code = c_OP_MUL; end
`endif
            default: ;
        endcase
    end

    assign w_a = {{OPW{1'b0}}, r_op1};
    assign w_b = {{OPW{1'b0}}, r_op2};

    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (r_opcode)
            c_OP_SUB: begin
                if (r_op1 >= r_op2) begin
                    w_mag = w_a - w_b;
                end else begin
                    w_mag = w_b - w_a;
                    w_neg = 1'b1;
                end
            end
`ifdef CALC_MUL_EN
            c_OP_MUL: w_mag = w_a * w_b;
`endif
            default:  w_mag = w_a + w_b;
        endcase
    end

    assign w_ovf = (w_mag > c_MAX_VAL);

    // Digit entry: exactly one target, decimal digit only, and only while idle.
    assign w_dig_ok  = is_num && (is_op1 ^ is_op2) && (num_val <= 4'd9) && (r_state == c_ST_IDLE);
    assign w_num_ext = {{(OPW-4){1'b0}}, num_val};
    assign w_op1_x10 = (r_op1 << 3) + (r_op1 << 1) + w_num_ext;
    assign w_op2_x10 = (r_op2 << 3) + (r_op2 << 1) + w_num_ext;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
        end
    endgenerate

    // The top adjusted bit is always zero for in-range magnitudes and is shifted out.
    assign w_bcd_next = {w_bcd_adj[BW-2:0], r_bin[OPW-1]};
    assign w_unused   = w_bcd_adj[BW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_opcode  <= c_OP_ADD;
            r_op1     <= '0;
            r_op2     <= '0;
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_fresh1  <= 1'b1;
            r_fresh2  <= 1'b1;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_iter    <= '0;
            r_neg     <= 1'b0;
            r_res_bcd <= '0;
            r_of      <= 1'b0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (w_dig_ok && is_op1) begin
                if (r_fresh1) begin
                    r_op1    <= w_num_ext;
                    r_cnt1   <= c_CNT_ONE;
                    r_fresh1 <= 1'b0;
                end else if (r_cnt1 < c_NDIG) begin
                    r_op1  <= w_op1_x10;
                    r_cnt1 <= r_cnt1 + c_CNT_ONE;
                end
            end
            if (w_dig_ok && is_op2) begin
                if (r_fresh2) begin
                    r_op2    <= w_num_ext;
                    r_cnt2   <= c_CNT_ONE;
                    r_fresh2 <= 1'b0;
                end else if (r_cnt2 < c_NDIG) begin
                    r_op2  <= w_op2_x10;
                    r_cnt2 <= r_cnt2 + c_CNT_ONE;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (save && w_op_legal) begin
                        r_opcode <= w_op_code;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b0;
                        r_state  <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    r_neg <= w_neg;
                    if (w_ovf) begin
                        r_of      <= 1'b1;
                        r_sign    <= 1'b0;
                        r_res_bcd <= '0;
                        r_busy    <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_bin   <= w_mag[OPW-1:0];
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= c_ST_CONV;
                    end
                end
                c_ST_CONV: begin
                    r_bcd  <= w_bcd_next;
                    r_bin  <= r_bin << 1;
                    r_iter <= r_iter + c_ITER_ONE;
                    // Outputs are published only here so they hold steady while busy.
                    if (r_iter == c_LAST_ITER) begin
                        r_res_bcd <= w_bcd_next;
                        r_of      <= 1'b0;
                        r_sign    <= r_neg;
                        r_busy    <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end
                default: begin
                    r_fresh1 <= 1'b1;
                    r_fresh2 <= 1'b1;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign op1_bin        = r_op1;
    assign op2_bin        = r_op2;
    assign alu_result_bcd = r_res_bcd;
    assign f_OF           = r_of;
    assign f_sig_res      = r_sign;
    assign busy           = r_busy;
    assign valid          = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_calc_core_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_core_param
// Description : Self-checking bench for calc_core_param against an arithmetic
//               reference model; honours CALC_MUL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_core_param;

    localparam int NDIG = 4;
    localparam int OPW  = 14;
    localparam int MAXV = 10 ** NDIG - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                is_num;
    logic                is_op1;
    logic                is_op2;
    logic [3:0]          num_val;
    logic [3:0]          op_val;
    logic                save;
    logic [OPW-1:0]      op1_bin;
    logic [OPW-1:0]      op2_bin;
    logic [4*NDIG-1:0]   alu_result_bcd;
    logic                f_OF;
    logic                f_sig_res;
    logic                busy;
    logic                valid;

    always #5 clk = ~clk;

    calc_core_param #(.NDIG(NDIG), .OPW(OPW)) dut (
        .clk            (clk),
        .rst            (rst),
        .is_num         (is_num),
        .is_op1         (is_op1),
        .is_op2         (is_op2),
        .num_val        (num_val),
        .op_val         (op_val),
        .save           (save),
        .op1_bin        (op1_bin),
        .op2_bin        (op2_bin),
        .alu_result_bcd (alu_result_bcd),
        .f_OF           (f_OF),
        .f_sig_res      (f_sig_res),
        .busy           (busy),
        .valid          (valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: operand values, digit counts and fresh flags.
    int m_op1, m_op2, m_cnt1, m_cnt2;
    bit m_f1, m_f2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*NDIG-1:0] to_bcd(input int v);
        logic [4*NDIG-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_op1 = 0; m_op2 = 0; m_cnt1 = 0; m_cnt2 = 0;
        m_f1 = 1'b1; m_f2 = 1'b1;
    endtask

    task automatic enter(input bit s1, input bit s2, input logic [3:0] d);
        is_num = 1'b1; is_op1 = s1; is_op2 = s2; num_val = d;
        tick();
        is_num = 1'b0; is_op1 = 1'b0; is_op2 = 1'b0; num_val = 4'd0;
        if ((s1 ^ s2) && d <= 4'd9) begin
            if (s1) begin
                if (m_f1) begin m_op1 = int'(d); m_cnt1 = 1; m_f1 = 1'b0; end
                else if (m_cnt1 < NDIG) begin m_op1 = m_op1 * 10 + int'(d); m_cnt1++; end
            end else begin
                if (m_f2) begin m_op2 = int'(d); m_cnt2 = 1; m_f2 = 1'b0; end
                else if (m_cnt2 < NDIG) begin m_op2 = m_op2 * 10 + int'(d); m_cnt2++; end
            end
        end
        chk("op1_bin", 32'(op1_bin), 32'(m_op1));
        chk("op2_bin", 32'(op2_bin), 32'(m_op2));
    endtask

    task automatic enter_val(input bit to1, input int v, input int nd);
        for (int k = nd - 1; k >= 0; k--)
            enter(to1, !to1, 4'((v / (10 ** k)) % 10));
    endtask

    task automatic run_op(input logic [3:0] code, input int mid_save_at);
        bit                legal, neg, ovf, held, busy_ok;
        int                mag, edge_n;
        logic [4*NDIG-1:0] pb;
        logic              po, ps, pv;
        legal = (code == 4'b1101) || (code == 4'b1110);
`ifdef CALC_MUL_EN
        legal = legal || (code == 4'b1100);
`endif
        pb = alu_result_bcd; po = f_OF; ps = f_sig_res; pv = valid;
        save = 1'b1; op_val = code;
        tick();
        save = 1'b0; op_val = 4'd0;
        if (!legal) begin
            chk("ign_busy",  32'(busy), 32'(0));
            chk("ign_valid", 32'(valid), 32'(pv));
            chk("ign_bcd",   32'(alu_result_bcd), 32'(pb));
            chk("ign_of",    32'(f_OF), 32'(po));
            return;
        end
        neg = 1'b0;
        if (code == 4'b1101)      mag = m_op1 + m_op2;
        else if (code == 4'b1110) begin
            if (m_op1 >= m_op2) mag = m_op1 - m_op2;
            else begin mag = m_op2 - m_op1; neg = 1'b1; end
        end else                  mag = m_op1 * m_op2;
        ovf = (mag > MAXV);
        chk("busy_e1",  32'(busy), 32'(1));
        chk("valid_e1", 32'(valid), 32'(0));
        edge_n = 1; held = 1'b1; busy_ok = 1'b1;
        while (!valid && edge_n < 64) begin
            if (alu_result_bcd !== pb || f_OF !== po || f_sig_res !== ps) held = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (edge_n == mid_save_at) begin save = 1'b1; op_val = 4'b1110; end
            tick();
            save = 1'b0; op_val = 4'd0;
            edge_n++;
        end
        chk("hold_while_busy", 32'(held), 32'(1));
        chk("busy_until_valid", 32'(busy_ok), 32'(1));
        chk("latency", 32'(edge_n), ovf ? 32'(2) : 32'(OPW + 2));
        chk("busy_done", 32'(busy), 32'(0));
        chk("result_bcd", 32'(alu_result_bcd), ovf ? 32'(0) : 32'(to_bcd(mag)));
        chk("f_OF", 32'(f_OF), 32'(ovf));
        chk("f_sig_res", 32'(f_sig_res), ovf ? 32'(0) : 32'(neg));
        m_f1 = 1'b1; m_f2 = 1'b1;
        tick();
        chk("valid_held", 32'(valid), 32'(1));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] code;
        rst = 1'b1; is_num = 1'b0; is_op1 = 1'b0; is_op2 = 1'b0;
        num_val = 4'd0; op_val = 4'd0; save = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_busy",  32'(busy), 32'(0));
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_bcd",   32'(alu_result_bcd), 32'(0));
        chk("rst_flags", 32'({f_OF, f_sig_res}), 32'(0));
        chk("rst_ops",   32'({op1_bin, op2_bin}), 32'(0));
        rst = 1'b0;
        tick();

        // Basic add, then both subtraction directions.
        enter_val(1'b1, 1234, 4);
        enter_val(1'b0, 5678, 4);
        run_op(4'b1101, 0);
        run_op(4'b1110, 0);
        enter_val(1'b1, 5678, 4);
        enter_val(1'b0, 1234, 4);
        run_op(4'b1110, 0);

        // Overflow on add, and a zero subtraction result.
        enter_val(1'b1, 9999, 4);
        enter_val(1'b0, 1, 1);
        run_op(4'b1101, 0);
        enter_val(1'b1, 5, 1);
        enter_val(1'b0, 5, 1);
        run_op(4'b1110, 0);

        // Entry limits and ignored digit forms.
        enter_val(1'b1, 12345, 5);
        enter(1'b1, 1'b0, 4'hA);
        enter(1'b1, 1'b1, 4'd3);
        enter(1'b0, 1'b0, 4'd3);
        enter_val(1'b0, 5678, 4);
        run_op(4'b1101, 0);
        enter(1'b1, 1'b0, 4'd7);
        chk("valid_kept_on_entry", 32'(valid), 32'(1));

        // save pulsed mid-conversion is ignored.
        run_op(4'b1101, 6);

        // Reset mid-conversion.
        save = 1'b1; op_val = 4'b1101;
        tick();
        save = 1'b0; op_val = 4'd0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midrst_busy",  32'(busy), 32'(0));
        chk("midrst_valid", 32'(valid), 32'(0));
        chk("midrst_bcd",   32'(alu_result_bcd), 32'(0));
        chk("midrst_flags", 32'({f_OF, f_sig_res}), 32'(0));
        chk("midrst_ops",   32'({op1_bin, op2_bin}), 32'(0));
        enter_val(1'b1, 12, 2);
        enter_val(1'b0, 34, 2);
        run_op(4'b1101, 0);

        // Multiply code: legal only when the feature is built in.
        enter_val(1'b1, 99, 2);
        enter_val(1'b0, 99, 2);
        run_op(4'b1100, 0);
        enter_val(1'b1, 100, 3);
        enter_val(1'b0, 100, 3);
        run_op(4'b1100, 0);
        run_op(4'b0000, 0);

        // Randomised operands, noise entries and op codes.
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < int'($urandom_range(1, 5)); k++)
                enter(1'b1, 1'b0, 4'($urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) enter(1'b1, 1'b1, 4'($urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) enter(1'b0, 1'b1, 4'($urandom_range(10, 15)));
            for (int k = 0; k < int'($urandom_range(1, 5)); k++)
                enter(1'b0, 1'b1, 4'($urandom_range(0, 9)));
            case ($urandom_range(0, 3))
                0:       code = 4'b1101;
                1:       code = 4'b1110;
                2:       code = 4'b1100;
                default: code = 4'($urandom_range(0, 15));
            endcase
            run_op(code, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
- Parametrised successor of the calculator datapath.
- Accepts decimal keypad digits into two unsigned operands. On a save strobe it computes add, subtract or (optionally) multiply.
- Converts the magnitude to BCD with a sequential double-dabble engine and a busy/valid handshake.
- Sits between the keypad decoder and the display driver. Digit count is generic; fixed width is replaced by parameters.

Parameters:
- NDIG, 4, number of decimal digits per operand and per result.
- OPW, 14, binary operand width; must satisfy 2^OPW > 10^NDIG-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- is_num  in  1  num_val carries a digit this cycle.
- is_op1  in  1  digit targets operand 1.
- is_op2  in  1  digit targets operand 2.
- num_val  in  4  decimal digit 0-9.
- op_val  in  4  operation code: 4'b1101 add, 4'b1110 sub, 4'b1100 mul (optional feature only).
- save  in  1  start strobe; op_val is sampled with it.
- op1_bin  out  OPW  operand 1, binary.
- op2_bin  out  OPW  operand 2, binary.
- alu_result_bcd  out  4*NDIG  result magnitude, BCD, most significant digit at the top.
- f_OF  out  1  result magnitude exceeded 10^NDIG-1.
- f_sig_res  out  1  result negative.
- busy  out  1  operation in progress.
- valid  out  1  result outputs hold a completed result.

Behaviour:
- Reset (rst=1 at a rising edge): all outputs are 0, state is IDLE, digit counters are 0, and both fresh flags are set. Reset has priority over everything, including mid-CONV.

Digit entry (IDLE only; ignored while busy):
- Entry fires when is_num=1 and exactly one of is_op1/is_op2 is 1. Both selects high, or neither, means no update.
- num_val>9 is ignored.
- If the target's fresh flag is set: operand=num_val, digit count=1, fresh flag cleared.
- Otherwise, if digit count<NDIG: operand=operand*10+num_val, count+1.
- Otherwise the digit is ignored (no wrap, no saturation to 9s).
- Operands update on the edge that samples the digit.

FSM states: IDLE, CALC, CONV, DONE.
- IDLE: save=1 with a legal op_val latches the op, sets busy=1 and valid=0, and goes to CALC. An illegal op_val ignores save; nothing changes.
- CALC (1 cycle):
  - add: mag=op1+op2, sign 0.
  - sub: if op1>=op2 then mag=op1-op2, sign 0; else mag=op2-op1, sign 1.
  - mul: mag=op1*op2, sign 0.
  - Internal width is 2*OPW.
  - f_sig_res is registered. Zero result gives sign 0.
  - If mag>10^NDIG-1: f_OF=1, f_sig_res=0, alu_result_bcd=0, go to DONE.
  - Otherwise f_OF=0, load the shifter, go to CONV.
- CONV: one double-dabble iteration per cycle for exactly OPW cycles (add-3 to every BCD digit >=5, then shift left 1). After the last iteration, alu_result_bcd is written and the FSM goes to DONE.
- DONE: busy=0, valid=1, both fresh flags set. Next cycle returns to IDLE with valid held.

Latency and handshake:
- Count the save-sampling edge as edge 1. valid rises at edge OPW+2 (edge 16 at default parameters), or at edge 2 on overflow.
- busy is high from edge 1 until valid rises.
- valid stays high until the next accepted save or reset.
- alu_result_bcd, f_OF and f_sig_res hold their last values while busy.
- save while busy is ignored.
- Digits entered while valid=1 are legal, go to IDLE entry, and do not drop valid.

Optional Feature:
- Macro CALC_MUL_EN.
- Defined: op 4'b1100 is legal and multiplies. Result overflow is checked against 10^NDIG-1 before conversion.
- Undefined: 4'b1100 is illegal (save ignored) and no multiplier is synthesised.

Test Plan:
1. Reset, enter op1=1,2,3,4 and op2=5,6,7,8, save with op_val=1101 -> op1_bin=1234, op2_bin=5678; busy for 15 cycles; valid at edge 16 with alu_result_bcd=16'h6912, f_OF=0, f_sig_res=0.
2. Same operands, save with 1110 -> alu_result_bcd=16'h4444, f_sig_res=1; then op1=5678, op2=1234, sub -> 16'h4444, f_sig_res=0.
3. op1=9999, op2=1, add -> f_OF=1, alu_result_bcd=0, valid at edge 2, busy only 1 cycle.
4. Enter 1,2,3,4,5 into op1 -> op1_bin=1234. num_val=4'hA ignored. is_op1=is_op2=1 ignored. After a completed op, entering 7 into op1 -> op1_bin=7 while op2_bin keeps 5678.
5. Save pulsed again mid-CONV -> ignored, result unchanged. Then rst=1 mid-CONV -> next edge: busy=0, valid=0, all outputs 0, and a fresh save works normally.
6. With CALC_MUL_EN: 99*99 -> 16'h9801; 100*100 -> f_OF=1. Without CALC_MUL_EN: save with 1100 -> busy stays 0, outputs unchanged.
